// File: rtl/j11_pkg.sv
// ---------------------------------------------------------------------------
// j11_pkg
// Shared definitions for the DL11-style console responder on the J11 bus:
// default I/O-page base and interrupt vectors, register selector encoding
// (byte address bits [2:1]) and CSR bit positions.
// ---------------------------------------------------------------------------
package j11_pkg;

    localparam logic [21:0] DEF_BASE  = 22'o17777560;
    localparam logic [15:0] DEF_RXVEC = 16'o060;
    localparam logic [15:0] DEF_TXVEC = 16'o064;

    // Word offset within the 8-byte register block.
    typedef enum logic [1:0] {
        REG_RCSR = 2'd0,
        REG_RBUF = 2'd1,
        REG_XCSR = 2'd2,
        REG_XBUF = 2'd3
    } reg_sel_e;

    localparam int CSR_DONE = 7;
    localparam int CSR_IE   = 6;
    localparam int CSR_RDY  = 7;

    localparam int RXFIFO_DEPTH = 16;

endpackage

// File: rtl/j11fifo.sv
// ---------------------------------------------------------------------------
// j11fifo
// Show-ahead synchronous FIFO: rdata always presents the head entry; pop
// advances to the next one. Push while full and pop while empty are ignored.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, wdata     write strobe and data
//   pop             discard head entry
//   rdata           head entry (meaningful only while !empty)
//   empty, full     occupancy flags
// ---------------------------------------------------------------------------
module j11fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rdata   = mem[rptr];

    // NOTE: storage has no reset; occupancy is tracked by count, so stale
    // entries are never observed as valid and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= bump(wptr);
            if (do_pop)  rptr <= bump(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/j11dl11.sv
// ---------------------------------------------------------------------------
// j11dl11
// DL11-style console serial responder on the internal J11 bus. Decodes the
// four I/O-page words RCSR/RBUF/XCSR/XBUF at BASE, answers reads, writes and
// interrupt acknowledges with a single-cycle busack, moves bytes to/from the
// rx/tx byte streams and raises the BR4 interrupt request.
//
// Build option: DL11_RXFIFO_EN replaces the single receive holding register
// with a 16-entry receive FIFO (DONE = FIFO not empty).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   busreq                   1-cycle request; other bus inputs stable to ack
//   buswr, busgp, busirq     write / general-purpose / interrupt-ack flags
//   busaddr[21:0]            byte address
//   buswdata[15:0], buswstrb byte enables {hi,lo}
//   busack                   1-cycle completion, one cycle after busreq
//   busrdata[15:0]           read data with busack, 0 otherwise
//   irq                      BR4 request
//   rx_data, rx_valid, rx_ready   received byte stream (sink)
//   tx_data, tx_valid, tx_ready   transmit byte stream (source)
// ---------------------------------------------------------------------------
module j11dl11
    import j11_pkg::*;
#(
    parameter logic [21:0] BASE  = DEF_BASE,
    parameter logic [15:0] RXVEC = DEF_RXVEC,
    parameter logic [15:0] TXVEC = DEF_TXVEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        busreq,
    input  logic        buswr,
    input  logic        busgp,
    input  logic        busirq,
    input  logic [21:0] busaddr,
    input  logic [15:0] buswdata,
    input  logic [1:0]  buswstrb,
    output logic        busack,
    output logic [15:0] busrdata,
    output logic        irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    reg_sel_e    sel;
    logic        hit;
    logic        claim;
    logic        iack;
    logic        acc;
    logic        wr_lo;
    logic        rbuf_rd;
    logic        xbuf_wr;
    logic [15:0] rdata;

    logic        done;
    logic        rdy;
    logic        rie;
    logic        xie;
    logic [7:0]  rx_head;

    logic        rx_term;
    logic        tx_term;
    logic        rx_term_q;
    logic        tx_term_q;
    logic        rxint;
    logic        txint;
    logic        rxint_n;
    logic        txint_n;

    // Only the low data byte and low strobe carry meaning here.
    logic        unused_bits;
    assign unused_bits = ^{buswdata[15:8], buswstrb[1], busaddr[0]};

    // Transmitter is ready exactly when no byte is being offered.
    assign rdy = ~tx_valid;

    // -----------------------------------------------------------------------
    // Bus decode and read mux
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        sel     = reg_sel_e'(busaddr[2:1]);
        hit     = (busaddr[21:3] == BASE[21:3]);
        // A request arriving while an ack is being driven is a protocol
        // violation and is dropped.
        claim   = busreq && !busack && !busgp && (busirq ? irq : hit);
        iack    = claim && busirq;
        acc     = claim && !busirq;
        wr_lo   = acc && buswr && buswstrb[0];
        rbuf_rd = acc && !buswr && (sel == REG_RBUF);
        xbuf_wr = wr_lo && (sel == REG_XBUF) && rdy;

        rdata = '0;
        if (iack) begin
            rdata = rxint ? RXVEC : TXVEC;
        end else if (acc && !buswr) begin
            case (sel)
                REG_RCSR: begin
                    rdata[CSR_DONE] = done;
                    rdata[CSR_IE]   = rie;
                end
                REG_RBUF: rdata = {8'h00, rx_head};
                REG_XCSR: begin
                    rdata[CSR_RDY] = rdy;
                    rdata[CSR_IE]  = xie;
                end
                default:  rdata = '0;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Receive path
    // -----------------------------------------------------------------------
`ifdef DL11_RXFIFO_EN
    logic fifo_empty;
    logic fifo_full;

    j11fifo #(
        .DEPTH (RXFIFO_DEPTH),
        .WIDTH (8)
    ) u_rxfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rbuf_rd),
        .rdata (rx_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign done     = ~fifo_empty;
    assign rx_ready = ~fifo_full;
`else
    // Single holding register; rx_ready drops while a byte awaits RBUF read,
    // so an arrival and an RBUF read never contend for DONE.
    assign rx_ready = ~done;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            rx_head <= 8'h00;
        end else if (rx_valid && rx_ready) begin
            rx_head <= rx_data;
            done    <= 1'b1;
        end else if (rbuf_rd) begin
            done    <= 1'b0;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Transmit path: tx_data only changes when a new byte is accepted, so it
    // is stable for the whole time tx_valid is high.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else if (xbuf_wr) begin
            tx_valid <= 1'b1;
            tx_data  <= buswdata[7:0];
        end else if (tx_valid && tx_ready) begin
            tx_valid <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Interrupt flags: armed on the rising edge of (flag & IE), dropped when
    // the term falls or on acknowledge. The acknowledge clear is applied last
    // so it wins over a same-cycle set.
    // -----------------------------------------------------------------------
    assign rx_term = done & rie;
    assign tx_term = rdy & xie;

    always_comb begin
        rxint_n = rxint;
        if (!rx_term)        rxint_n = 1'b0;
        else if (!rx_term_q) rxint_n = 1'b1;
        if (iack && rxint)   rxint_n = 1'b0;

        txint_n = txint;
        if (!tx_term)        txint_n = 1'b0;
        else if (!tx_term_q) txint_n = 1'b1;
        if (iack && !rxint)  txint_n = 1'b0;
    end

    // -----------------------------------------------------------------------
    // Bus response, interrupt-enable bits and interrupt state. All side
    // effects land on the same edge that raises busack.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busack    <= 1'b0;
            busrdata  <= '0;
            rie       <= 1'b0;
            xie       <= 1'b0;
            rx_term_q <= 1'b0;
            tx_term_q <= 1'b0;
            rxint     <= 1'b0;
            txint     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            busack   <= claim;
            busrdata <= rdata;
            if (wr_lo && (sel == REG_RCSR)) rie <= buswdata[CSR_IE];
            if (wr_lo && (sel == REG_XCSR)) xie <= buswdata[CSR_IE];
            rx_term_q <= rx_term;
            tx_term_q <= tx_term;
            rxint     <= rxint_n;
            txint     <= txint_n;
            irq       <= rxint_n | txint_n;
        end
    end

endmodule
